// File: rtl/renode_ahb_manager_bridge.sv
// -----------------------------------------------------------------------------
// renode_ahb_manager_bridge
//
// Purpose:
//   AHB-Lite manager that converts a valid/ready command stream into single,
//   non-pipelined AHB transfers and returns exactly one response per command.
//   Only one transfer is ever outstanding.
//   Commands that are oversized for the data bus or misaligned are answered
//   with an error response and never reach the bus.
//
// Ports:
//   hclk, hreset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_write/addr/size/wdata         command payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata/rsp_error               response payload
//   haddr/htrans/hwrite/hsize/hburst/hprot/hwdata   AHB manager outputs
//   hready/hrdata/hresp               AHB subordinate returns
// -----------------------------------------------------------------------------
module renode_ahb_manager_bridge #(
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned DataWidth    = 32,
    parameter logic [3:0]  HprotValue   = 4'b0011
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [AddressWidth-1:0] cmd_addr,
    input  logic [2:0]              cmd_size,
    input  logic [DataWidth-1:0]    cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DataWidth-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic [AddressWidth-1:0] haddr,
    output logic [1:0]              htrans,
    output logic                    hwrite,
    output logic [2:0]              hsize,
    output logic [2:0]              hburst,
    output logic [3:0]              hprot,
    output logic [DataWidth-1:0]    hwdata,
    input  logic                    hready,
    input  logic [DataWidth-1:0]    hrdata,
    input  logic                    hresp
);

    // Largest legal hsize: one full data-bus word.
    localparam logic [2:0] MaxSize = (DataWidth == 64) ? 3'd3 : 3'd2;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_ERR  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    // A command is legal when it fits the data bus and is naturally aligned.
    function automatic logic cmd_is_legal(input logic [2:0] size, input logic [2:0] addr_lsb);
        logic [2:0] mask;
        mask = 3'b111;
        case (size)
            3'd0:    mask = 3'b000;
            3'd1:    mask = 3'b001;
            3'd2:    mask = 3'b011;
            3'd3:    mask = 3'b111;
            default: mask = 3'b111;
        endcase
        return (size <= MaxSize) && ((addr_lsb & mask) == 3'b000);
    endfunction

    state_t                  r_state;
    logic                    r_rsp_valid;
    logic [DataWidth-1:0]    r_rsp_rdata;
    logic                    r_rsp_error;
    logic [AddressWidth-1:0] r_haddr;
    logic [1:0]              r_htrans;
    logic                    r_hwrite;
    logic [2:0]              r_hsize;
    logic [DataWidth-1:0]    r_hwdata;

    state_t                  w_state_nxt;
    logic                    w_rsp_valid_nxt;
    logic [DataWidth-1:0]    w_rsp_rdata_nxt;
    logic                    w_rsp_error_nxt;
    logic [AddressWidth-1:0] w_haddr_nxt;
    logic [1:0]              w_htrans_nxt;
    logic                    w_hwrite_nxt;
    logic [2:0]              w_hsize_nxt;
    logic [DataWidth-1:0]    w_hwdata_nxt;
    logic                    w_cmd_ready;
    logic                    w_cmd_legal;

    // cmd_ready is the only combinational output; it is masked during reset.
    assign w_cmd_ready = (r_state == S_IDLE) && !hreset;
    assign w_cmd_legal = cmd_is_legal(cmd_size, cmd_addr[2:0]);

    assign cmd_ready = w_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign haddr     = r_haddr;
    assign htrans    = r_htrans;
    assign hwrite    = r_hwrite;
    assign hsize     = r_hsize;
    assign hburst    = 3'b000;
    assign hprot     = HprotValue;
    assign hwdata    = r_hwdata;

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_error_nxt = r_rsp_error;
        w_haddr_nxt     = r_haddr;
        w_htrans_nxt    = r_htrans;
        w_hwrite_nxt    = r_hwrite;
        w_hsize_nxt     = r_hsize;
        w_hwdata_nxt    = r_hwdata;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && w_cmd_ready) begin
                    if (w_cmd_legal) begin
                        w_state_nxt  = S_ADDR;
                        w_haddr_nxt  = cmd_addr;
                        w_hwrite_nxt = cmd_write;
                        w_hsize_nxt  = cmd_size;
                        w_hwdata_nxt = cmd_wdata;
                        w_htrans_nxt = HtransNonseq;
                    end else begin
                        // Rejected commands answer directly without touching the bus.
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = {DataWidth{1'b0}};
                        w_rsp_error_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADDR: begin
                // hready low here stalls a foreign data phase; keep NONSEQ steady.
                if (hready) begin
                    w_htrans_nxt = HtransIdle;
                    w_state_nxt  = S_DATA;
                end else begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_DATA: begin
                if (hready) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_hwrite ? {DataWidth{1'b0}} : hrdata;
                    w_rsp_error_nxt = hresp;
                end else if (hresp) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_ERR: begin
                // Second cycle of the two-cycle ERROR response ends the transfer.
                if (hready) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = {DataWidth{1'b0}};
                    w_rsp_error_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_htrans_nxt    = HtransIdle;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DataWidth{1'b0}};
            r_rsp_error <= 1'b0;
            r_haddr     <= {AddressWidth{1'b0}};
            r_htrans    <= HtransIdle;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'd0;
            r_hwdata    <= {DataWidth{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_error <= w_rsp_error_nxt;
            r_haddr     <= w_haddr_nxt;
            r_htrans    <= w_htrans_nxt;
            r_hwrite    <= w_hwrite_nxt;
            r_hsize     <= w_hsize_nxt;
            r_hwdata    <= w_hwdata_nxt;
        end
    end

endmodule
